rx_pkt_fifo: RTL and testbench

Receive-side packet descriptor queue that sits directly downstream of the endpoint receive FSM. Each time the FSM commits a CRC-clean packet to the rx cache, it pulses a push with the packet's 7-bit metadata `{id, req}`. This block queues those descriptors for the software/bus-side consumer and returns a full indication that the FSM samples as `overflow`. It also keeps saturating counts of CRC-failed packets and of descriptors dropped on a full queue.

---
 rtl/rx_pkt_fifo_if.sv | 25 ++
 rtl/rx_pkt_fifo.sv | 58 +++++
 tb/tb_rx_pkt_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rx_pkt_fifo_if.sv
// rx_pkt_fifo_if: descriptor push/pop and error-counter bundle for rx_pkt_fifo
interface rx_pkt_fifo_if #(
  parameter int DEPTH = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                       push;
  logic [6:0]                 push_metadata;
  logic                       crc_error;
  logic                       overflow;
  logic                       pop;
  logic                       pop_valid;
  logic [6:0]                 pop_metadata;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [ERR_CNT_WIDTH-1:0]   crc_err_count;
  logic [ERR_CNT_WIDTH-1:0]   drop_count;
  logic                       clear_counts;
  modport master (
    output push, push_metadata, crc_error, pop, clear_counts,
    input  overflow, pop_valid, pop_metadata, count, crc_err_count, drop_count
  );
  modport slave (
    input  push, push_metadata, crc_error, pop, clear_counts,
    output overflow, pop_valid, pop_metadata, count, crc_err_count, drop_count
  );
endinterface

// File: rtl/rx_pkt_fifo.sv
// rx_pkt_fifo: first-word fall-through rx descriptor queue with saturating crc/drop counters
module rx_pkt_fifo #(
  parameter int DEPTH = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic clk,
  input logic n_rst,
  rx_pkt_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [6:0]               mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     full_q, full_d, valid_q, valid_d;
  logic [ERR_CNT_WIDTH-1:0] crc_q, crc_d, drop_q, drop_d;
  logic                     push_ok, pop_ok, drop;
  always_comb begin
    push_ok  = bus.push && (!full_q || bus.pop);
    pop_ok   = bus.pop && valid_q;
    drop     = bus.push && full_q && !bus.pop;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d   = count_d == CW'(DEPTH);
    valid_d  = count_d != '0;
    crc_d    = bus.clear_counts ? '0 : (bus.crc_error && !(&crc_q)) ? crc_q + 1'b1 : crc_q;
    drop_d   = bus.clear_counts ? '0 : (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      crc_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      crc_q    <= crc_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.push_metadata;
  end
  assign bus.overflow      = full_q;
  assign bus.pop_valid     = valid_q;
  assign bus.pop_metadata  = mem_q[rd_ptr_q];
  assign bus.count         = count_q;
  assign bus.crc_err_count = crc_q;
  assign bus.drop_count    = drop_q;
endmodule

// File: tb/tb_rx_pkt_fifo.sv
// tb_rx_pkt_fifo: directed self-checking bench for rx_pkt_fifo
module tb_rx_pkt_fifo;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q [$];
  rx_pkt_fifo_if #(.DEPTH(8), .ERR_CNT_WIDTH(8)) bus ();
  rx_pkt_fifo #(.DEPTH(8), .ERR_CNT_WIDTH(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic [6:0] md, input logic q, input logic crc, input logic clr);
    bus.push = p;
    bus.push_metadata = md;
    bus.pop = q;
    bus.crc_error = crc;
    bus.clear_counts = clr;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.crc_error = 1'b0;
    bus.clear_counts = 1'b0;
  endtask
  initial begin
    bus.push = 1'b0;
    bus.push_metadata = '0;
    bus.pop = 1'b0;
    bus.crc_error = 1'b0;
    bus.clear_counts = 1'b0;
    #12;
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.pop_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_crc", bus.crc_err_count, 0);
    check("rst_drop", bus.drop_count, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc(1, 7'h11, 0, 0, 0);
    check("push1_valid", bus.pop_valid, 1);
    check("push1_head", bus.pop_metadata, 7'h11);
    cyc(1, 7'h22, 0, 0, 0);
    cyc(1, 7'h33, 0, 0, 0);
    check("push3_count", bus.count, 3);
    check("push3_head", bus.pop_metadata, 7'h11);
    check("pop1_md", bus.pop_metadata, 7'h11);
    cyc(0, 0, 1, 0, 0);
    check("pop2_md", bus.pop_metadata, 7'h22);
    cyc(0, 0, 1, 0, 0);
    check("pop3_md", bus.pop_metadata, 7'h33);
    cyc(0, 0, 1, 0, 0);
    check("drain_valid", bus.pop_valid, 0);
    check("drain_count", bus.count, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 7'(8'h40 + i), 0, 0, 0);
      check($sformatf("fill_ovf%0d", i), bus.overflow, i == 7);
    end
    check("full_count", bus.count, 8);
    cyc(1, 7'h7F, 0, 0, 0);
    check("drop_cnt", bus.drop_count, 1);
    check("drop_count_occ", bus.count, 8);
    check("drop_head", bus.pop_metadata, 7'h40);
    cyc(1, 7'h55, 1, 0, 0);
    check("fullpp_count", bus.count, 8);
    check("fullpp_ovf", bus.overflow, 1);
    check("fullpp_head", bus.pop_metadata, 7'h41);
    check("fullpp_drop", bus.drop_count, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_md%0d", i), bus.pop_metadata, i == 7 ? 7'h55 : 7'(8'h41 + i));
      cyc(0, 0, 1, 0, 0);
      check($sformatf("drain_ovf%0d", i), bus.overflow, 0);
    end
    check("empty_valid", bus.pop_valid, 0);
    cyc(1, 7'h0A, 1, 0, 0);
    check("emptypp_count", bus.count, 1);
    check("emptypp_valid", bus.pop_valid, 1);
    check("emptypp_head", bus.pop_metadata, 7'h0A);
    cyc(0, 0, 1, 0, 0);
    check("pop_last_count", bus.count, 0);
    cyc(0, 0, 1, 0, 0);
    check("pop_empty_count", bus.count, 0);
    check("pop_empty_valid", bus.pop_valid, 0);
    check("pop_empty_ovf", bus.overflow, 0);
    cyc(1, 7'h60, 0, 0, 0);
    exp_q.push_back(7'h60);
    for (int i = 0; i < 20; i++) begin
      logic p, q;
      logic [6:0] v;
      p = (i % 4) != 3;
      q = (i % 4) != 0;
      v = 7'(8'h61 + i);
      if (q) check($sformatf("wrap_md%0d", i), bus.pop_metadata, exp_q[0]);
      cyc(p, v, q, 0, 0);
      if (q) void'(exp_q.pop_front());
      if (p) exp_q.push_back(v);
      check($sformatf("wrap_cnt%0d", i), bus.count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      check("wrap_drain", bus.pop_metadata, exp_q.pop_front());
      cyc(0, 0, 1, 0, 0);
    end
    check("wrap_empty", bus.count, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    check("crc5", bus.crc_err_count, 5);
    for (int i = 0; i < 295; i++) cyc(0, 0, 0, 1, 0);
    check("crc_sat", bus.crc_err_count, 255);
    cyc(0, 0, 0, 1, 1);
    check("crc_clr", bus.crc_err_count, 0);
    check("drop_clr", bus.drop_count, 0);
    cyc(1, 7'h01, 0, 0, 0);
    cyc(1, 7'h02, 0, 0, 0);
    check("pre_rst_count", bus.count, 2);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_valid", bus.pop_valid, 0);
    check("async_rst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
